// File: rtl/univ_update_reg.sv
// Universal WIDTH-bit register: hold, load, shift, rotate, increment and
// decrement, with change flag, saturating change counter, wrap pulse and a
// serial-out bit.
module univ_update_reg #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             changed,
  output logic [CNT_W-1:0] upd_cnt,
  output logic             cnt_sat,
  output logic             wrapped
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_changed;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sat;
  logic             r_wrapped;

  logic [WIDTH-1:0] w_q_nxt;
  logic             w_sout_nxt;
  logic             w_wrap_nxt;
  logic             w_chg;
  logic [CNT_W-1:0] w_cnt_nxt;

  // Next register value, serial-out bit and wrap detection for the selected mode.
  always_comb begin
    w_q_nxt    = r_q;
    w_sout_nxt = r_sout;
    w_wrap_nxt = 1'b0;
    if (en) begin
      case (mode)
        MODE_HOLD: w_q_nxt = r_q;
        MODE_LOAD: w_q_nxt = d;
        MODE_SHL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], sin};
          w_sout_nxt = r_q[WIDTH-1];
        end
        MODE_SHR: begin
          w_q_nxt    = {sin, r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        MODE_ROL: begin
          w_q_nxt    = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
          w_sout_nxt = r_q[WIDTH-1];
        end
        MODE_ROR: begin
          w_q_nxt    = {r_q[0], r_q[WIDTH-1:1]};
          w_sout_nxt = r_q[0];
        end
        MODE_INC: begin
          w_q_nxt    = r_q + WIDTH'(1);
          w_wrap_nxt = (r_q == '1);
        end
        MODE_DEC: begin
          w_q_nxt    = r_q - WIDTH'(1);
          w_wrap_nxt = (r_q == '0);
        end
        default: w_q_nxt = r_q;
      endcase
    end
  end

  // Change detection and saturating counter update.
  always_comb begin
    w_chg     = (w_q_nxt != r_q);
    w_cnt_nxt = r_cnt;
    if (w_chg && (r_cnt != '1)) begin
      w_cnt_nxt = r_cnt + CNT_W'(1);
    end
  end

  // State registers; saturation flag is registered alongside the counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q       <= '0;
      r_sout    <= 1'b0;
      r_changed <= 1'b0;
      r_cnt     <= '0;
      r_sat     <= 1'b0;
      r_wrapped <= 1'b0;
    end else begin
      r_q       <= w_q_nxt;
      r_sout    <= w_sout_nxt;
      r_changed <= w_chg;
      r_cnt     <= w_cnt_nxt;
      r_sat     <= (w_cnt_nxt == '1);
      r_wrapped <= w_wrap_nxt;
    end
  end

  assign q       = r_q;
  assign sout    = r_sout;
  assign changed = r_changed;
  assign upd_cnt = r_cnt;
  assign cnt_sat = r_sat;
  assign wrapped = r_wrapped;

endmodule
